// File: rtl/pe1_unbf_pkg.sv
// Shared constants for the inverse add/sub butterfly processing element.
//   DATA_WIDTH       coefficient width
//   Q                modulus; every coefficient lies in [0, Q-1]
//   PE_UNBF_LATENCY  input-to-output latency in non-hold cycles
package pe1_unbf_pkg;

  localparam int unsigned DATA_WIDTH      = 12;
  localparam int unsigned Q               = 3329;
  localparam int unsigned PE_UNBF_LATENCY = 7;

endpackage

// File: rtl/mod_half.sv
// Combinational modular halving y = x * 2^-1 mod q (q odd).
// Even x halves directly; odd x has q added first so the sum is even.
// Ports:
//   x_i  operand in [0, q-1]
//   y_o  result in [0, q-1]
module mod_half #(
  parameter int unsigned data_width = 12,
  parameter int unsigned q          = 3329
) (
  input  logic [data_width-1:0] x_i,
  output logic [data_width-1:0] y_o
);

  localparam logic [data_width:0] QX = (data_width+1)'(q);

  logic [data_width:0] ext;

  always_comb begin
    ext = x_i[0] ? ({1'b0, x_i} + QX) : {1'b0, x_i};
    y_o = ext[data_width:1];
  end

endmodule

// File: rtl/modular_add.sv
// Combinational modular addition y = (a + b) mod q for a, b in [0, q-1].
// Ports:
//   a_i, b_i  operands
//   y_o       result in [0, q-1]
module modular_add #(
  parameter int unsigned data_width = 12,
  parameter int unsigned q          = 3329
) (
  input  logic [data_width-1:0] a_i,
  input  logic [data_width-1:0] b_i,
  output logic [data_width-1:0] y_o
);

  localparam logic [data_width:0] QX = (data_width+1)'(q);

  logic [data_width:0] sum;
  logic [data_width:0] red;

  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    red = sum - QX;
    y_o = (sum >= QX) ? red[data_width-1:0] : sum[data_width-1:0];
  end

endmodule

// File: rtl/modular_substraction.sv
// Combinational modular subtraction y = (a - b) mod q for a, b in [0, q-1].
// Ports:
//   a_i  minuend
//   b_i  subtrahend
//   y_o  result in [0, q-1]
module modular_substraction #(
  parameter int unsigned data_width = 12,
  parameter int unsigned q          = 3329
) (
  input  logic [data_width-1:0] a_i,
  input  logic [data_width-1:0] b_i,
  output logic [data_width-1:0] y_o
);

  localparam logic [data_width:0] QX = (data_width+1)'(q);

  logic [data_width:0] diff;
  logic [data_width:0] wrap;

  always_comb begin
    diff = {1'b0, a_i} - {1'b0, b_i};
    wrap = diff + QX;
    y_o  = (a_i >= b_i) ? diff[data_width-1:0] : wrap[data_width-1:0];
  end

endmodule

// File: rtl/shifter.sv
// Fixed-depth shift register with enable and asynchronous active-high reset.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset, clears every stage
//   en_i   when 1, all stages advance by one; when 0, all stages hold
//   d_i    data entering the first stage
//   q_o    data leaving the last stage (depth cycles after entry)
module shifter #(
  parameter int unsigned width = 12,
  parameter int unsigned depth = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  logic [width-1:0] stage_q [depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < depth; i++) begin
        stage_q[i] <= '0;
      end
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[depth-1];

endmodule

// File: rtl/pe1_unbf.sv
// Inverse add/sub butterfly: from (bf_upper = u-v, bf_lower = u+v) mod q
// recovers u = (lower+upper)/2 and v = (lower-upper)/2 mod q.
// Latency pre_depth + mid_depth + 1 non-hold cycles; hold freezes everything.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   hold         freezes all pipeline registers; the input that cycle is dropped
//   in_valid     qualifies the input sample
//   sel_half     1: halve the sum/difference, 0: emit raw sum/difference
//   bf_upper     difference operand
//   bf_lower     sum operand
//   out_valid    qualifies u_out/v_out
//   u_out,v_out  recovered pair (or raw sum/difference when bypassed)
module pe1_unbf
  import pe1_unbf_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH,
  parameter int unsigned q          = Q,
  parameter int unsigned pre_depth  = 3,
  parameter int unsigned mid_depth  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  in_valid,
  input  logic                  sel_half,
  input  logic [data_width-1:0] bf_upper,
  input  logic [data_width-1:0] bf_lower,
  output logic                  out_valid,
  output logic [data_width-1:0] u_out,
  output logic [data_width-1:0] v_out
);

  logic                    en;
  logic [2*data_width-1:0] pre_q;
  logic [data_width-1:0]   s;
  logic [data_width-1:0]   d;
  logic [2*data_width-1:0] mid_q;
  logic [1:0]              vm_q;
  logic [data_width-1:0]   hs;
  logic [data_width-1:0]   hd;

  logic                  valid_q, valid_d;
  logic [data_width-1:0] u_q, u_d;
  logic [data_width-1:0] v_q, v_d;

  assign en = ~hold;

  shifter #(.width(2*data_width), .depth(pre_depth)) u_pre (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (en),
    .d_i   ({bf_upper, bf_lower}),
    .q_o   (pre_q)
  );

  modular_add #(.data_width(data_width), .q(q)) u_add (
    .a_i (pre_q[data_width-1:0]),
    .b_i (pre_q[2*data_width-1:data_width]),
    .y_o (s)
  );

  modular_substraction #(.data_width(data_width), .q(q)) u_sub (
    .a_i (pre_q[data_width-1:0]),
    .b_i (pre_q[2*data_width-1:data_width]),
    .y_o (d)
  );

  shifter #(.width(2*data_width), .depth(mid_depth)) u_mid (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (en),
    .d_i   ({s, d}),
    .q_o   (mid_q)
  );

  // {valid, mode} rides alongside the data up to the halving stage; the
  // output register below provides the final valid stage.
  shifter #(.width(2), .depth(pre_depth + mid_depth)) u_vm (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (en),
    .d_i   ({in_valid, sel_half}),
    .q_o   (vm_q)
  );

  mod_half #(.data_width(data_width), .q(q)) u_half_s (
    .x_i (mid_q[2*data_width-1:data_width]),
    .y_o (hs)
  );

  mod_half #(.data_width(data_width), .q(q)) u_half_d (
    .x_i (mid_q[data_width-1:0]),
    .y_o (hd)
  );

  always_comb begin
    valid_d = vm_q[1];
    u_d     = vm_q[0] ? hs : mid_q[2*data_width-1:data_width];
    v_d     = vm_q[0] ? hd : mid_q[data_width-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      u_q     <= '0;
      v_q     <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      u_q     <= u_d;
      v_q     <= v_d;
    end
  end

  assign out_valid = valid_q;
  assign u_out     = u_q;
  assign v_out     = v_q;

endmodule

// File: tb/tb_pe1_unbf.sv
// Self-checking bench for pe1_unbf: directed vectors, hold, mid-flight reset
// and randomized round-trip through a forward-butterfly model.
module tb_pe1_unbf;

  localparam int unsigned QM   = 3329;
  localparam int unsigned INV2 = 1665;  // 2 * 1665 = 1 mod 3329
  localparam int unsigned LAT  = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        in_valid;
  logic        sel_half;
  logic [11:0] bf_upper;
  logic [11:0] bf_lower;
  logic        out_valid;
  logic [11:0] u_out;
  logic [11:0] v_out;

  pe1_unbf #(.data_width(12), .q(QM), .pre_depth(3), .mid_depth(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .in_valid  (in_valid),
    .sel_half  (sel_half),
    .bf_upper  (bf_upper),
    .bf_lower  (bf_lower),
    .out_valid (out_valid),
    .u_out     (u_out),
    .v_out     (v_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    int unsigned eu;
    int unsigned ev;
  } exp_t;

  exp_t        pend[$];
  int unsigned nonhold_cnt = 0;
  bit          last_hold   = 1'b0;
  bit          prev_expv   = 1'b0;
  int unsigned prev_u      = 0;
  int unsigned prev_v      = 0;
  int unsigned errors      = 0;
  int unsigned checks      = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare the DUT state produced by the previous rising edge.
  task automatic compare();
    bit   expv;
    exp_t e;
    if (last_hold) begin
      check("out_valid_hold", int'(out_valid), int'(prev_expv));
      if (prev_expv) begin
        check("u_hold", u_out, prev_u);
        check("v_hold", v_out, prev_v);
      end
    end else begin
      while (pend.size() > 0 && pend[0].due < nonhold_cnt) begin
        e = pend.pop_front();
        check("missed_sample", 0, 1);
      end
      expv = (pend.size() > 0 && pend[0].due == nonhold_cnt);
      check("out_valid", int'(out_valid), int'(expv));
      if (expv) begin
        e = pend.pop_front();
        check("u_out", u_out, e.eu);
        check("v_out", v_out, e.ev);
        prev_u = e.eu;
        prev_v = e.ev;
      end
      prev_expv = expv;
    end
  endtask

  task automatic drive(input bit h, input bit vld, input bit s,
                       input int unsigned up, input int unsigned lo,
                       input int unsigned eu, input int unsigned ev);
    exp_t e;
    @(negedge clk);
    compare();
    hold     = h;
    in_valid = vld;
    sel_half = s;
    bf_upper = 12'(up);
    bf_lower = 12'(lo);
    @(posedge clk);
    if (!rst && !hold) begin
      if (in_valid) begin
        e.due = nonhold_cnt + LAT;
        e.eu  = eu;
        e.ev  = ev;
        pend.push_back(e);
      end
      nonhold_cnt++;
    end
    last_hold = hold;
  endtask

  // Expected output computed from the raw operands with plain arithmetic.
  task automatic step_raw(input bit h, input bit vld, input bit s,
                          input int unsigned up, input int unsigned lo);
    int unsigned sm, df;
    sm = (lo + up) % QM;
    df = (lo + QM - up) % QM;
    if (s) drive(h, vld, s, up, lo, (sm * INV2) % QM, (df * INV2) % QM);
    else   drive(h, vld, s, up, lo, sm, df);
  endtask

  // Forward butterfly of (u, v); the inverse must return (u, v) exactly.
  task automatic step_rt(input bit h, input int unsigned u, input int unsigned v);
    drive(h, 1'b1, 1'b1, (u + QM - v) % QM, (u + v) % QM, u, v);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step_raw(1'b0, 1'b0, 1'b1, 0, 0);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; in_valid = 1'b0; sel_half = 1'b1;
    bf_upper = '0; bf_lower = '0;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_u_out", u_out, 0);
    check("rst_v_out", v_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic, wrap/odd and bypass vectors
    step_raw(1'b0, 1'b1, 1'b1, 2, 8);
    idle(9);
    step_raw(1'b0, 1'b1, 1'b1, 3327, 8);
    step_raw(1'b0, 1'b1, 1'b1, 1, 3328);
    step_raw(1'b0, 1'b1, 1'b0, 2, 8);
    idle(8);

    // Alternating mode, back to back
    for (int unsigned i = 0; i < 10; i++)
      step_raw(1'b0, 1'b1, i[0], $urandom_range(QM-1), $urandom_range(QM-1));
    idle(8);

    // Hold for three cycles in the middle of a ten-sample stream; the sample
    // presented while held must be ignored.
    for (int unsigned i = 1; i <= 13; i++) begin
      if (i >= 5 && i <= 7) step_raw(1'b1, 1'b1, 1'b1, 4000, 4000);
      else step_raw(1'b0, 1'b1, 1'b1, i, 3 * i);
    end
    idle(10);

    // Asynchronous reset with five samples in flight
    for (int unsigned i = 0; i < 5; i++) step_rt(1'b0, 100 + i, 200 + i);
    @(negedge clk);
    compare();
    in_valid = 1'b0;
    hold     = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_u", u_out, 0);
    check("async_rst_v", v_out, 0);
    pend.delete();
    prev_expv = 1'b0;
    last_hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step_rt(1'b0, 1234, 4);
    idle(9);

    // Random round trip with random hold and gaps
    for (int unsigned i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) step_raw(1'b1, 1'b1, 1'b1, 5, 5);
      else if ($urandom_range(7) == 0) idle(1);
      else step_rt(1'b0, $urandom_range(QM-1), $urandom_range(QM-1));
    end
    idle(10);

    // Random raw operands with random mode, including boundary values
    for (int unsigned i = 0; i < 300; i++) begin
      int unsigned a, b;
      a = (i % 7 == 0) ? QM - 1 : $urandom_range(QM-1);
      b = (i % 5 == 0) ? 0 : $urandom_range(QM-1);
      step_raw($urandom_range(5) == 0, 1'b1, $urandom_range(1) == 1, a, b);
    end
    idle(12);
    check("drain_empty", pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
